vector_completion_unit: RTL and testbench



---
 rtl/vector_completion_unit.sv | 164 ++++++++++++++++
 tb/tb_vector_completion_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vector_completion_unit.sv
// Vector-side completion unit: accepts issued instructions, models ALU latency,
// forwards loads/stores to the memory unit and returns completion pulses.
module vector_completion_unit #(
    parameter int INSTRUCTION_BITS            = 32,
    parameter int REGISTER_NUMBERS            = 32,
    parameter int MULTICYCLE_OPERATION_CYCLES = 2,
    localparam int DEST_W                     = $clog2(REGISTER_NUMBERS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_vector,
    input  logic [INSTRUCTION_BITS-1:0] instruction,
    output logic                        ready_vector,
    output logic                        mem_req_valid,
    output logic                        mem_req_load,
    output logic [DEST_W-1:0]           mem_req_dest,
    input  logic                        mem_req_ready,
    input  logic                        mem_resp_valid,
    output logic                        operation_done,
    output logic [DEST_W-1:0]           alu_dest,
    output logic                        read_done,
    output logic                        store_done,
    output logic [DEST_W-1:0]           mem_dest
);

    localparam int CNT_W = $clog2(MULTICYCLE_OPERATION_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULTICYCLE_OPERATION_CYCLES - 1);

    typedef enum logic {ALU_IDLE, ALU_MUL} alu_state_t;
    typedef enum logic [1:0] {MEM_IDLE, MEM_REQ, MEM_WAIT} mem_state_t;

    alu_state_t alu_state_q, alu_state_d;
    mem_state_t mem_state_q, mem_state_d;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [5:0]        funct6;
    logic [DEST_W-1:0] rd;
    logic              is_lane, is_load, is_store, is_mul;
    logic              unused_bits;

    assign opcode      = instruction[6:0];
    assign funct3      = instruction[14:12];
    assign funct6      = instruction[31:26];
    assign rd          = instruction[7 +: DEST_W];
    assign unused_bits = ^instruction[25:15];

    function automatic logic mul_decode(input logic [2:0] f3, input logic [5:0] f6);
        logic f6_hit;
        f6_hit = (f6 == 6'b100100) || (f6 == 6'b100101) || (f6 == 6'b100110) ||
                 (f6 == 6'b100111) || (f6 == 6'b101001) || (f6 == 6'b101101);
        return ((f3 == 3'b010) || (f3 == 3'b110)) && f6_hit;
    endfunction

    assign is_lane  = (opcode == 7'b1010111) && (funct3 != 3'b111);
    assign is_load  = (opcode == 7'b0000111);
    assign is_store = (opcode == 7'b0100111);
    assign is_mul   = is_lane && mul_decode(funct3, funct6);

    // vset and unknown opcodes are always accepted and silently dropped
    always_comb begin
        ready_vector = rst_n;
        if (is_lane)
            ready_vector = rst_n && (alu_state_q == ALU_IDLE);
        else if (is_load || is_store)
            ready_vector = rst_n && (mem_state_q == MEM_IDLE);
    end

    logic lane_acc, mem_acc, mul_finish, mem_fin;
    assign lane_acc = valid_vector && ready_vector && is_lane;
    assign mem_acc  = valid_vector && ready_vector && (is_load || is_store);

    // ---------------- ALU timing model ----------------
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DEST_W-1:0] mul_dest_q;
    logic              vld_p0;
    logic [DEST_W-1:0] dest_p0;

    assign mul_finish = (alu_state_q == ALU_MUL) && (cnt_q == CNT_LAST);

    always_comb begin
        alu_state_d = alu_state_q;
        cnt_d       = cnt_q;
        case (alu_state_q)
            ALU_IDLE: if (lane_acc && is_mul) begin
                alu_state_d = ALU_MUL;
                cnt_d       = CNT_W'(1);
            end
            ALU_MUL: if (mul_finish) begin
                alu_state_d = ALU_IDLE;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            default: alu_state_d = ALU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_state_q <= ALU_IDLE;
            cnt_q       <= '0;
            mul_dest_q  <= '0;
            vld_p0      <= 1'b0;
            dest_p0     <= '0;
        end else begin
            alu_state_q <= alu_state_d;
            cnt_q       <= cnt_d;
            if (lane_acc && is_mul)
                mul_dest_q <= rd;
            vld_p0 <= (lane_acc && !is_mul) || mul_finish;
            if (mul_finish)
                dest_p0 <= mul_dest_q;
            else if (lane_acc && !is_mul)
                dest_p0 <= rd;
        end
    end

    assign operation_done = vld_p0;
    assign alu_dest       = dest_p0;

    // ---------------- memory request FSM ----------------
    logic              req_load_q;
    logic [DEST_W-1:0] req_dest_q;
    logic [DEST_W-1:0] last_mem_dest_q;

    assign mem_fin = (mem_state_q == MEM_WAIT) && mem_resp_valid;

    always_comb begin
        mem_state_d = mem_state_q;
        case (mem_state_q)
            MEM_IDLE: if (mem_acc)       mem_state_d = MEM_REQ;
            MEM_REQ:  if (mem_req_ready) mem_state_d = MEM_WAIT;
            MEM_WAIT: if (mem_resp_valid) mem_state_d = MEM_IDLE;
            default:  mem_state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_state_q     <= MEM_IDLE;
            req_load_q      <= 1'b0;
            req_dest_q      <= '0;
            last_mem_dest_q <= '0;
        end else begin
            mem_state_q <= mem_state_d;
            if (mem_acc) begin
                req_load_q <= is_load;
                req_dest_q <= rd;
            end
            if (mem_fin)
                last_mem_dest_q <= req_dest_q;
        end
    end

    // Done pulses are combinational so the FSM is back in idle the following cycle
    assign mem_req_valid = (mem_state_q == MEM_REQ);
    assign mem_req_load  = req_load_q;
    assign mem_req_dest  = req_dest_q;
    assign read_done     = mem_fin && req_load_q;
    assign store_done    = mem_fin && !req_load_q;
    assign mem_dest      = mem_fin ? req_dest_q : last_mem_dest_q;

endmodule

// File: tb/tb_vector_completion_unit.sv
// Directed bench for vector_completion_unit with hand-computed expectations.
module tb_vector_completion_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_vector;
    logic [31:0] instruction;
    logic        ready_vector;
    logic        mem_req_valid, mem_req_load;
    logic [4:0]  mem_req_dest;
    logic        mem_req_ready, mem_resp_valid;
    logic        operation_done;
    logic [4:0]  alu_dest;
    logic        read_done, store_done;
    logic [4:0]  mem_dest;

    int n_checks = 0;
    int n_pass   = 0;

    vector_completion_unit #(
        .INSTRUCTION_BITS(32),
        .REGISTER_NUMBERS(32),
        .MULTICYCLE_OPERATION_CYCLES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_vector(valid_vector), .instruction(instruction), .ready_vector(ready_vector),
        .mem_req_valid(mem_req_valid), .mem_req_load(mem_req_load), .mem_req_dest(mem_req_dest),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .operation_done(operation_done), .alu_dest(alu_dest),
        .read_done(read_done), .store_done(store_done), .mem_dest(mem_dest)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] vop(input logic [5:0] f6, input logic [2:0] f3, input logic [4:0] rd);
        return {f6, 1'b1, 10'd0, f3, rd, 7'b1010111};
    endfunction

    function automatic logic [31:0] vld(input logic [4:0] rd);
        return {17'd0, 3'b000, rd, 7'b0000111};
    endfunction

    function automatic logic [31:0] vst(input logic [4:0] rd);
        return {17'd0, 3'b000, rd, 7'b0100111};
    endfunction

    initial begin
        rst_n = 1'b0; valid_vector = 1'b0; instruction = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        #12;
        check("rst_ready", ready_vector, 0);
        check("rst_opdone", operation_done, 0);
        check("rst_reqvalid", mem_req_valid, 0);
        check("rst_rdone", read_done, 0);
        check("rst_sdone", store_done, 0);
        rst_n = 1'b1;
        tick();

        // single-cycle vadd rd=5
        valid_vector = 1'b1; instruction = vop(6'b000000, 3'b000, 5'd5);
        #1 check("vadd_ready", ready_vector, 1);
        tick();
        valid_vector = 1'b0;
        check("vadd_done", operation_done, 1);
        check("vadd_dest", alu_dest, 5);
        tick();
        check("vadd_done_once", operation_done, 0);

        // back-to-back vadd rd=1,2,3
        for (int i = 1; i <= 3; i++) begin
            valid_vector = 1'b1; instruction = vop(6'b000000, 3'b000, 5'(i));
            #1 check($sformatf("b2b_ready%0d", i), ready_vector, 1);
            tick();
            check($sformatf("b2b_done%0d", i), operation_done, 1);
            check($sformatf("b2b_dest%0d", i), alu_dest, i);
        end
        valid_vector = 1'b0;
        tick();
        check("b2b_idle", operation_done, 0);

        // vmul rd=7 then vadd rd=8 presented immediately
        valid_vector = 1'b1; instruction = vop(6'b100101, 3'b010, 5'd7);
        tick();
        instruction = vop(6'b000000, 3'b000, 5'd8);
        #1 check("mul_block_ready", ready_vector, 0);
        check("mul_wait_done", operation_done, 0);
        tick();
        check("mul_done", operation_done, 1);
        check("mul_dest", alu_dest, 7);
        check("mul_ready_in_done", ready_vector, 1);
        tick();
        valid_vector = 1'b0;
        check("after_mul_done", operation_done, 1);
        check("after_mul_dest", alu_dest, 8);
        tick();
        check("after_mul_idle", operation_done, 0);
        check("dest_hold", alu_dest, 8);

        // second mul encoding: funct3 110, funct6 101101, rd=12
        valid_vector = 1'b1; instruction = vop(6'b101101, 3'b110, 5'd12);
        tick();
        valid_vector = 1'b0;
        check("mul2_not_early", operation_done, 0);
        tick();
        check("mul2_done", operation_done, 1);
        check("mul2_dest", alu_dest, 12);

        // load rd=9 with delayed grant; store presented meanwhile
        valid_vector = 1'b1; instruction = vld(5'd9);
        mem_resp_valid = 1'b1;
        #1 check("ld_ready", ready_vector, 1);
        tick();
        instruction = vst(5'd4);
        #1 check("st_blocked", ready_vector, 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ld_reqv%0d", i), mem_req_valid, 1);
            check($sformatf("ld_reqload%0d", i), mem_req_load, 1);
            check($sformatf("ld_reqdest%0d", i), mem_req_dest, 9);
            check($sformatf("ld_noearly%0d", i), read_done, 0);
            tick();
        end
        mem_resp_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("ld_wait_reqv", mem_req_valid, 0);
        tick();
        check("ld_wait_nodone", read_done, 0);
        mem_resp_valid = 1'b1;
        #1 check("ld_rdone", read_done, 1);
        check("ld_sdone", store_done, 0);
        check("ld_mdest", mem_dest, 9);
        check("st_blocked_done", ready_vector, 0);
        tick();
        mem_resp_valid = 1'b0;
        #1 check("ld_rdone_once", read_done, 0);
        check("st_ready", ready_vector, 1);
        tick();
        valid_vector = 1'b0;
        check("st_reqload", mem_req_load, 0);
        check("st_reqdest", mem_req_dest, 4);
        check("mdest_hold", mem_dest, 9);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        valid_vector = 1'b1; instruction = vop(6'b000000, 3'b000, 5'd6);
        tick();
        valid_vector = 1'b0;
        mem_resp_valid = 1'b1;
        #1 check("both_sdone", store_done, 1);
        check("both_rdone", read_done, 0);
        check("both_mdest", mem_dest, 4);
        check("both_opdone", operation_done, 1);
        check("both_adest", alu_dest, 6);
        tick();
        mem_resp_valid = 1'b0;

        // vset accepted, no pulses
        valid_vector = 1'b1; instruction = vop(6'b000000, 3'b111, 5'd3);
        #1 check("vset_ready", ready_vector, 1);
        tick();
        valid_vector = 1'b0;
        check("vset_noop", operation_done, 0);
        check("vset_noreq", mem_req_valid, 0);

        // reset with a load and a mul in flight
        valid_vector = 1'b1; instruction = vld(5'd10);
        tick();
        instruction = vop(6'b100100, 3'b010, 5'd11);
        tick();
        valid_vector = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("rst_mid_reqv", mem_req_valid, 0);
        check("rst_mid_reqdest", mem_req_dest, 0);
        check("rst_mid_ready", ready_vector, 0);
        check("rst_mid_opdone", operation_done, 0);
        tick();
        rst_n = 1'b1;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("post_rst_op%0d", i), operation_done, 0);
            check($sformatf("post_rst_rd%0d", i), read_done, 0);
            check($sformatf("post_rst_req%0d", i), mem_req_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
